popcount_stream_acc: RTL

- Sequential frame-level popcount. Consumes a valid/ready stream of 8-bit words and produces the total set-bit count of each frame, where a frame ends on the word flagged `in_last`.
- Computes the per-word count by instantiating `popcount_int8` as the combinational core, then registers it, accumulates it and buffers the result under output backpressure.
- Sits directly downstream of `popcount_int8`, as the stage that consumes its 4-bit result. Used by PIM bit-counting benchmarks (Hamming weight, XNOR-popcount dot products).

---
 rtl/popcount_pkg.sv | 27 ++
 rtl/popcount_int8.sv | 33 +++
 rtl/popcount_stream_acc.sv | 116 +++++++++++
 3 files changed

// File: rtl/popcount_pkg.sv
// Shared constants and saturating-add helper for the popcount datapath.
// sat_add is width-generic up to SAT_W bits so other accumulators can reuse it.
package popcount_pkg;

    localparam int WORD_W    = 8;
    localparam int POPCNT8_W = 4;
    localparam int SAT_W     = 32;

    localparam logic [SAT_W:0] SAT_ONE = {{SAT_W{1'b0}}, 1'b1};

    // Returns {carry, sum}; sum clamps to 2^w-1 and carry flags the clamp.
    function automatic logic [SAT_W:0] sat_add(
        input logic [SAT_W-1:0] acc,
        input logic [SAT_W-1:0] inc,
        input int unsigned      w
    );
        logic [SAT_W:0] sum;
        logic [SAT_W:0] lim;
        sum = {1'b0, acc} + {1'b0, inc};
        lim = (SAT_ONE << w) - SAT_ONE;
        if (sum > lim) begin
            return {1'b1, lim[SAT_W-1:0]};
        end
        return {1'b0, sum[SAT_W-1:0]};
    endfunction

endpackage

// File: rtl/popcount_int8.sv
// Combinational 8-bit population count (0..8).
// IMPL_TYPE 0 builds a balanced adder tree; any other value a serial chain.
module popcount_int8
    import popcount_pkg::*;
#(
    parameter int IMPL_TYPE = 0
) (
    input  logic [WORD_W-1:0]    data,
    output logic [POPCNT8_W-1:0] count
);

    generate
        if (IMPL_TYPE == 0) begin : g_tree
            logic [1:0] p0, p1, p2, p3;
            logic [2:0] q0, q1;
            assign p0 = {1'b0, data[0]} + {1'b0, data[1]};
            assign p1 = {1'b0, data[2]} + {1'b0, data[3]};
            assign p2 = {1'b0, data[4]} + {1'b0, data[5]};
            assign p3 = {1'b0, data[6]} + {1'b0, data[7]};
            assign q0 = {1'b0, p0} + {1'b0, p1};
            assign q1 = {1'b0, p2} + {1'b0, p3};
            assign count = {1'b0, q0} + {1'b0, q1};
        end else begin : g_chain
            always_comb begin
                count = '0;
                for (int i = 0; i < WORD_W; i++) begin
                    count = count + {{(POPCNT8_W-1){1'b0}}, data[i]};
                end
            end
        end
    endgenerate

endmodule

// File: rtl/popcount_stream_acc.sv
// Frame-level popcount: registers per-word counts, accumulates them and
// holds each frame total in a one-deep output buffer under backpressure.
module popcount_stream_acc
    import popcount_pkg::*;
#(
    parameter int ACC_WIDTH = 16,
    parameter int IMPL_TYPE = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORD_W-1:0]    in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_count,
    output logic                 out_ovf
);

    logic                 s1_valid_q, s1_valid_d;
    logic                 s1_last_q, s1_last_d;
    logic [POPCNT8_W-1:0] s1_pc_q, s1_pc_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 acc_ovf_q, acc_ovf_d;
    logic                 out_valid_q, out_valid_d;
    logic [ACC_WIDTH-1:0] out_count_q, out_count_d;
    logic                 out_ovf_q, out_ovf_d;

    logic [POPCNT8_W-1:0] word_pc;
    logic                 in_xfer, out_xfer, consume, emit;
    logic [SAT_W:0]       sat_r, sat_unused;
    logic [ACC_WIDTH-1:0] sat_sum;
    logic                 sat_carry;

    popcount_int8 #(
        .IMPL_TYPE(IMPL_TYPE)
    ) u_pc (
        .data (in_data),
        .count(word_pc)
    );

    // A last word may not leave stage 1 while the output buffer is stalled.
    assign consume  = s1_valid_q && !(s1_last_q && out_valid_q && !out_ready);
    assign emit     = consume && s1_last_q;
    assign in_ready = !s1_valid_q || consume;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid_q && out_ready;

    assign sat_r      = sat_add(SAT_W'(acc_q), SAT_W'(s1_pc_q),
                                unsigned'(ACC_WIDTH));
    assign sat_carry  = sat_r[SAT_W];
    assign sat_sum    = sat_r[ACC_WIDTH-1:0];
    assign sat_unused = sat_r;

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_last_d   = s1_last_q;
        s1_pc_d     = s1_pc_q;
        acc_d       = acc_q;
        acc_ovf_d   = acc_ovf_q;
        out_valid_d = out_valid_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;

        if (in_xfer) begin
            s1_valid_d = 1'b1;
            s1_pc_d    = word_pc;
            s1_last_d  = in_last;
        end else if (consume) begin
            s1_valid_d = 1'b0;
        end

        if (out_xfer) begin
            out_valid_d = 1'b0;
        end

        if (emit) begin
            out_count_d = sat_sum;
            out_ovf_d   = acc_ovf_q | sat_carry;
            out_valid_d = 1'b1;
            acc_d       = '0;
            acc_ovf_d   = 1'b0;
        end else if (consume) begin
            acc_d     = sat_sum;
            acc_ovf_d = acc_ovf_q | sat_carry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_pc_q     <= '0;
            acc_q       <= '0;
            acc_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            s1_pc_q     <= s1_pc_d;
            acc_q       <= acc_d;
            acc_ovf_q   <= acc_ovf_d;
            out_valid_q <= out_valid_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

endmodule
